fetch_unit: RTL and testbench

- PC sequencer and instruction register for the S-Machine CPU. Sits directly upstream of the 256x16 instruction memory.
- Drives the 8-bit PC address to the memory and captures the returned 16-bit word into an instruction register. The memory read is combinational, so the word for the current PC is available in the same cycle.
- Hands the captured word to decode over a valid/ready handshake.
- Handles branch redirect, halt/drain and resume.

---
 rtl/s_machine_pkg.sv | 18 +
 rtl/fetch_ir_reg.sv | 58 +++++
 rtl/fetch_unit.sv | 108 ++++++++++
 tb/tb_fetch_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/s_machine_pkg.sv
// Shared types and constants for the S-Machine fetch path.
package s_machine_pkg;

    localparam int PC_W   = 8;
    localparam int INST_W = 16;

    typedef logic [PC_W-1:0]   pc_t;
    typedef logic [INST_W-1:0] inst_t;

    typedef enum logic [1:0] {
        FS_RUN    = 2'd0,
        FS_DRAIN  = 2'd1,
        FS_HALTED = 2'd2
    } fetch_state_e;

    localparam pc_t RESET_PC_DEFAULT = 8'h00;

endpackage

// File: rtl/fetch_ir_reg.sv
// Valid/ready instruction register between fetch and decode, with flush.
module fetch_ir_reg #(
    parameter int PC_W   = 8,
    parameter int INST_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              flush,
    input  logic [INST_W-1:0] d_inst,
    input  logic [PC_W-1:0]   d_pc,
    input  logic              dec_ready,
    output logic [INST_W-1:0] ir,
    output logic [PC_W-1:0]   ir_pc,
    output logic              ir_valid
);

    logic [INST_W-1:0] ir_d, ir_q;
    logic [PC_W-1:0]   ir_pc_d, ir_pc_q;
    logic              ir_valid_d, ir_valid_q;
    logic              take;

    assign take = ir_valid_q && dec_ready;

    // Flush beats load; a take with no refill empties the register.
    always_comb begin
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        if (flush) begin
            ir_valid_d = 1'b0;
        end else if (load) begin
            ir_d       = d_inst;
            ir_pc_d    = d_pc;
            ir_valid_d = 1'b1;
        end else if (take) begin
            ir_valid_d = 1'b0;
        end
    end

    // Register state; async reset discards any held instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
        end else begin
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
        end
    end

    assign ir       = ir_q;
    assign ir_pc    = ir_pc_q;
    assign ir_valid = ir_valid_q;

endmodule

// File: rtl/fetch_unit.sv
// S-Machine PC sequencer: PC register, run/drain/halt control, IR handoff.
module fetch_unit #(
    parameter int              PC_W     = s_machine_pkg::PC_W,
    parameter int              INST_W   = s_machine_pkg::INST_W,
    parameter logic [PC_W-1:0] RESET_PC = s_machine_pkg::RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [PC_W-1:0]   pc,
    input  logic [INST_W-1:0] inst_in,
    output logic [INST_W-1:0] ir,
    output logic [PC_W-1:0]   ir_pc,
    output logic              ir_valid,
    input  logic              dec_ready,
    input  logic              br_en,
    input  logic [PC_W-1:0]   br_target,
    input  logic              halt_req,
    input  logic              resume,
    output logic              halted
);

    import s_machine_pkg::*;

    fetch_state_e    state_d, state_q;
    logic [PC_W-1:0] pc_d, pc_q;
    logic            halted_d, halted_q;
    logic            load;
    logic            flush;
    logic            take;

    assign take = ir_valid && dec_ready;

    // Next PC/state; a branch overrides load and stall, halt suppresses the load edge.
    always_comb begin
        pc_d     = pc_q;
        state_d  = state_q;
        halted_d = halted_q;
        load     = 1'b0;
        flush    = 1'b0;
        unique case (state_q)
            FS_RUN: begin
                if (br_en) begin
                    flush = 1'b1;
                    pc_d  = br_target;
                end else if (!halt_req && (!ir_valid || dec_ready)) begin
                    load = 1'b1;
                    pc_d = pc_q + 1'b1;
                end
                if (halt_req) state_d = FS_DRAIN;
            end
            FS_DRAIN: begin
                if (br_en) begin
                    flush    = 1'b1;
                    pc_d     = br_target;
                    state_d  = FS_HALTED;
                    halted_d = 1'b1;
                end else if (!ir_valid || take) begin
                    state_d  = FS_HALTED;
                    halted_d = 1'b1;
                end
            end
            FS_HALTED: begin
                if (br_en) pc_d = br_target;
                if (resume && !halt_req) begin
                    state_d  = FS_RUN;
                    halted_d = 1'b0;
                end
            end
            default: begin
                state_d  = FS_RUN;
                halted_d = 1'b0;
            end
        endcase
    end

    // PC, state and halted flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            state_q  <= FS_RUN;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            state_q  <= state_d;
            halted_q <= halted_d;
        end
    end

    fetch_ir_reg #(
        .PC_W   (PC_W),
        .INST_W (INST_W)
    ) u_ir (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .flush     (flush),
        .d_inst    (inst_in),
        .d_pc      (pc_q),
        .dec_ready (dec_ready),
        .ir        (ir),
        .ir_pc     (ir_pc),
        .ir_valid  (ir_valid)
    );

    assign pc     = pc_q;
    assign halted = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: scoreboard of decoded words plus directed state checks.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  pc;
    logic [15:0] inst_in;
    logic [15:0] ir;
    logic [7:0]  ir_pc;
    logic        ir_valid;
    logic        dec_ready;
    logic        br_en;
    logic [7:0]  br_target;
    logic        halt_req;
    logic        resume;
    logic        halted;

    int passed = 0;
    int total  = 0;

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] word;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pc        (pc),
        .inst_in   (inst_in),
        .ir        (ir),
        .ir_pc     (ir_pc),
        .ir_valid  (ir_valid),
        .dec_ready (dec_ready),
        .br_en     (br_en),
        .br_target (br_target),
        .halt_req  (halt_req),
        .resume    (resume),
        .halted    (halted)
    );

    // Instruction memory contents
    function automatic logic [15:0] word(input logic [7:0] a);
        if (a == 8'h00) return 16'h1111;
        if (a == 8'h01) return 16'h2222;
        return {a, ~a};
    endfunction

    always_comb inst_in = word(pc);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push(input logic [7:0] a);
        exp_t e;
        e.addr = a;
        e.word = word(a);
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted IR must match the next expected word in order
    always @(negedge clk) begin
        if (rst_n && ir_valid && dec_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL take_unexpected: got ir_pc=%0h ir=%0h expected no transfer", ir_pc, ir);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                total++;
                if (ir_pc === e.addr && ir === e.word) passed++;
                else $display("FAIL take: got ir_pc=%0h ir=%0h expected ir_pc=%0h ir=%0h",
                              ir_pc, ir, e.addr, e.word);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; dec_ready = 1'b1; br_en = 1'b0; br_target = 8'h00;
        halt_req = 1'b0; resume = 1'b0;
        #2;
        chk("rst_pc", pc, 8'h00);
        chk("rst_valid", ir_valid, 0);
        chk("rst_halted", halted, 0);
        chk("rst_ir", ir, 16'h0000);
        chk("rst_ir_pc", ir_pc, 8'h00);

        foreach (exp_q[i]) exp_q.delete(i);
        for (int a = 0; a <= 6; a++) push(8'(a));
        tick(); tick();
        rst_n = 1'b1;

        // Straight-line fetch
        tick();
        chk("e1_ir", ir, 16'h1111);
        chk("e1_ir_pc", ir_pc, 8'h00);
        tick();
        chk("e2_ir", ir, 16'h2222);
        chk("e2_ir_pc", ir_pc, 8'h01);
        chk("e2_pc", pc, 8'h02);
        for (int k = 0; k < 4; k++) tick();
        chk("e6_ir_pc", ir_pc, 8'h05);
        chk("e6_pc", pc, 8'h06);

        // Backpressure holds IR and PC
        dec_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_ir_pc", ir_pc, 8'h05);
            chk("bp_ir", ir, word(8'h05));
            chk("bp_pc", pc, 8'h06);
            chk("bp_valid", ir_valid, 1);
        end
        dec_ready = 1'b1;
        tick();
        chk("bp_rel_ir_pc", ir_pc, 8'h06);
        chk("bp_rel_pc", pc, 8'h07);

        // Branch flush and one-bubble redirect
        push(8'h40);
        br_en = 1'b1; br_target = 8'h40;
        tick();
        br_en = 1'b0;
        chk("br_valid", ir_valid, 0);
        chk("br_pc", pc, 8'h40);
        tick();
        chk("br_ir_pc", ir_pc, 8'h40);
        chk("br_valid2", ir_valid, 1);

        // PC wrap
        push(8'hFF); push(8'h00);
        br_en = 1'b1; br_target = 8'hFF;
        tick();
        br_en = 1'b0;
        chk("wr_pc_ff", pc, 8'hFF);
        tick();
        chk("wr_ir_pc_ff", ir_pc, 8'hFF);
        chk("wr_pc_00", pc, 8'h00);
        tick();
        chk("wr_ir_pc_00", ir_pc, 8'h00);
        chk("wr_pc_01", pc, 8'h01);

        // Halt with a stalled IR, then drain
        dec_ready = 1'b0; halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        chk("dr_pc", pc, 8'h01);
        chk("dr_valid", ir_valid, 1);
        chk("dr_halted", halted, 0);
        tick();
        chk("dr_pc2", pc, 8'h01);
        chk("dr_halted2", halted, 0);
        dec_ready = 1'b1;
        tick();
        chk("h_valid", ir_valid, 0);
        chk("h_halted", halted, 1);
        chk("h_pc", pc, 8'h01);
        tick();
        chk("h_halted2", halted, 1);
        chk("h_pc2", pc, 8'h01);

        // Resume with halt_req stays halted; plain resume restarts
        resume = 1'b1; halt_req = 1'b1;
        tick();
        chk("rh_halted", halted, 1);
        halt_req = 1'b0;
        tick();
        resume = 1'b0;
        chk("rs_halted", halted, 0);
        chk("rs_valid", ir_valid, 0);
        chk("rs_pc", pc, 8'h01);
        push(8'h01);
        tick();
        chk("rs_ir_pc", ir_pc, 8'h01);
        chk("rs_pc2", pc, 8'h02);

        // Async reset between edges
        br_en = 1'b1; br_target = 8'h22;
        tick();
        br_en = 1'b0; dec_ready = 1'b0;
        tick();
        chk("ar_pre_pc", pc, 8'h23);
        chk("ar_pre_valid", ir_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_pc", pc, 8'h00);
        chk("ar_valid", ir_valid, 0);
        chk("ar_halted", halted, 0);
        chk("ar_ir", ir, 16'h0000);

        chk("sb_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
